// File: rtl/filter_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | filter_ctrl_pkg : shared types and modulo-step helper for filter select |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_UP   = 2'd1,
    HOLD_DN   = 2'd2,
    BOTH_HELD = 2'd3
  } sel_state_t;

  localparam int N_FILTERS_DEFAULT = 5;

  // dir=1 steps up, dir=0 steps down; out-of-range indices wrap to 0 on UP.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input logic dir, input int n);
    logic [3:0] last;
    logic [3:0] sum;
    last = 4'(n - 1);
    if (dir)
      sum = ({1'b0, idx} >= last) ? 4'd0 : {1'b0, idx} + 4'd1;
    else
      sum = (idx == 3'd0) ? last : {1'b0, idx} - 4'd1;
    return sum[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debouncer : 2-flop synchroniser plus stable-level debounce counter |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int C_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [C_CW-1:0] r_cnt;
  logic            w_sync_pressed;

  assign w_sync_pressed = ~r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync      <= 2'b11;
      r_cnt       <= '0;
      pressed     <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], key_n};
      press_pulse <= 1'b0;
      if (w_sync_pressed != pressed) begin
        if (r_cnt == C_LAST) begin
          pressed     <= w_sync_pressed;
          press_pulse <= w_sync_pressed;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_select_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | filter_select_ctrl : UP/DOWN keys to filter index with auto-repeat   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module filter_select_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int N_FILTERS           = N_FILTERS_DEFAULT,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       enable,
  output logic [2:0] filter_number,
  output logic       filter_changed
);

  localparam int C_REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int C_REP_W   = (C_REP_MAX > 1) ? $clog2(C_REP_MAX) : 1;
  localparam logic [C_REP_W-1:0] C_DELAY_LAST = C_REP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [C_REP_W-1:0] C_RATE_LAST  = C_REP_W'(REPEAT_RATE_CYCLES - 1);

  logic w_up_pressed, w_up_press, w_dn_pressed, w_dn_press;
  logic [2:0]         w_next_up, w_next_dn;
  logic [C_REP_W-1:0] w_rep_last;

  sel_state_t         r_state;
  logic [C_REP_W-1:0] r_rep_cnt;
  logic               r_rep_fast;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .key_n(key_up_n),
    .pressed(w_up_pressed), .press_pulse(w_up_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk(clk), .reset(reset), .key_n(key_down_n),
    .pressed(w_dn_pressed), .press_pulse(w_dn_press)
  );

  assign w_next_up  = next_index(filter_number, 1'b1, N_FILTERS);
  assign w_next_dn  = next_index(filter_number, 1'b0, N_FILTERS);
  assign w_rep_last = r_rep_fast ? C_RATE_LAST : C_DELAY_LAST;

  // Entering a hold state always implies the other key was released, so in
  // the hold states a fresh press pulse is the only way the other key arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rep_cnt      <= '0;
      r_rep_fast     <= 1'b0;
      filter_number  <= 3'd0;
      filter_changed <= 1'b0;
    end else begin
      filter_changed <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rep_cnt  <= '0;
          r_rep_fast <= 1'b0;
          if (w_up_pressed && w_dn_pressed) begin
            r_state <= BOTH_HELD;
            if (enable) begin
              filter_number  <= 3'd0;
              filter_changed <= (filter_number != 3'd0);
            end
          end else if (w_up_pressed) begin
            r_state <= HOLD_UP;
            if (enable) begin
              filter_number  <= w_next_up;
              filter_changed <= (w_next_up != filter_number);
            end
          end else if (w_dn_pressed) begin
            r_state <= HOLD_DN;
            if (enable) begin
              filter_number  <= w_next_dn;
              filter_changed <= (w_next_dn != filter_number);
            end
          end
        end
        HOLD_UP, HOLD_DN: begin
          if ((r_state == HOLD_UP) ? w_dn_press : w_up_press) begin
            r_state <= BOTH_HELD;
            if (enable) begin
              filter_number  <= 3'd0;
              filter_changed <= (filter_number != 3'd0);
            end
          end else if ((r_state == HOLD_UP) ? !w_up_pressed : !w_dn_pressed) begin
            r_state <= IDLE;
          end else if (r_rep_cnt == w_rep_last) begin
            r_rep_cnt  <= '0;
            r_rep_fast <= 1'b1;
            if (enable) begin
              filter_number  <= (r_state == HOLD_UP) ? w_next_up : w_next_dn;
              filter_changed <= (((r_state == HOLD_UP) ? w_next_up : w_next_dn) != filter_number);
            end
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        BOTH_HELD: begin
          if (!w_up_pressed && !w_dn_pressed)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
